// File: rtl/ext_irq_arbiter.sv
// External interrupt arbiter: per-source level gateways, programmable
// priority/enable/threshold, claim/complete through a single-cycle register
// port, and a registered ext_int toward the machine-mode trap unit.
module ext_irq_arbiter #(
  parameter int unsigned NUM_SRC = 8,
  parameter int unsigned PRIO_W  = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               reg_valid,
  input  logic               reg_write,
  input  logic [7:0]         reg_addr,
  input  logic [31:0]        reg_wdata,
  output logic               reg_rvalid,
  output logic [31:0]        reg_rdata,
  output logic               ext_int
);

  localparam logic [1:0] GW_IDLE    = 2'd0;
  localparam logic [1:0] GW_PENDING = 2'd1;
  localparam logic [1:0] GW_CLAIMED = 2'd2;

  localparam logic [5:0] WORD_PENDING = 6'h20;
  localparam logic [5:0] WORD_ENABLE  = 6'h21;
  localparam logic [5:0] WORD_THRESH  = 6'h22;
  localparam logic [5:0] WORD_CLAIM   = 6'h23;

  logic [5:0]        word;
  logic              rd_req;
  logic              wr_req;
  logic              claim_go;
  logic              complete_go;
  logic [4:0]        complete_id;
  logic [NUM_SRC:1]  enable_q;
  logic [NUM_SRC:1]  pending;
  logic [PRIO_W-1:0] threshold_q;
  logic [4:0]        best_id;
  logic [PRIO_W-1:0] best_prio;
  logic [4:0]        win_id;
  logic [PRIO_W-1:0] win_prio;
  logic [PRIO_W-1:0] rd_prio;
  logic [31:0]       rd_data;
  logic              unused_bits;

  assign word        = reg_addr[7:2];
  assign rd_req      = reg_valid && !reg_write;
  assign wr_req      = reg_valid && reg_write;
  // A claim that would return 0 is a plain read and must not disturb the winner.
  assign claim_go    = rd_req && (word == WORD_CLAIM) && (best_id != '0);
  assign complete_go = wr_req && (word == WORD_CLAIM);
  assign complete_id = reg_wdata[4:0];

  // best_prio is kept alongside best_id for observability only.
  assign unused_bits = ^{reg_addr[1:0], reg_wdata, best_prio};

  // Per-source gateway, priority register and one link of the arbitration and
  // priority read-back chains; each link only replaces on a strictly higher
  // priority, so the lowest ID wins ties.
  for (genvar g = 1; g <= NUM_SRC; g++) begin : g_src
    logic [1:0]        state_q;
    logic [PRIO_W-1:0] prio_q;
    logic              eligible;
    logic              take;
    logic [4:0]        prev_id;
    logic [PRIO_W-1:0] prev_prio;
    logic [PRIO_W-1:0] prev_rd;
    logic [4:0]        win_id_l;
    logic [PRIO_W-1:0] win_prio_l;
    logic [PRIO_W-1:0] rd_prio_l;

    if (g == 1) begin : g_head
      assign prev_id   = '0;
      assign prev_prio = '0;
      assign prev_rd   = '0;
    end else begin : g_link
      assign prev_id   = g_src[g-1].win_id_l;
      assign prev_prio = g_src[g-1].win_prio_l;
      assign prev_rd   = g_src[g-1].rd_prio_l;
    end

    // Priority register write.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        prio_q <= '0;
      end else if (wr_req && (word == 6'(g))) begin
        prio_q <= reg_wdata[PRIO_W-1:0];
      end
    end

    // Gateway: latch a level once, hold through claim, re-arm on complete.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        state_q <= GW_IDLE;
      end else begin
        case (state_q)
          GW_IDLE:    if (irq_src[g-1]) state_q <= GW_PENDING;
          GW_PENDING: if (claim_go && (best_id == 5'(g))) state_q <= GW_CLAIMED;
          GW_CLAIMED: if (complete_go && (complete_id == 5'(g))) state_q <= GW_IDLE;
          default:    state_q <= GW_IDLE;
        endcase
      end
    end

    assign pending[g]  = (state_q == GW_PENDING);
    assign eligible    = pending[g] && enable_q[g] && (prio_q > threshold_q);
    assign take        = eligible && (prio_q > prev_prio);
    assign win_id_l    = take ? 5'(g) : prev_id;
    assign win_prio_l  = take ? prio_q : prev_prio;
    assign rd_prio_l   = prev_rd | ((word == 6'(g)) ? prio_q : '0);
  end

  assign win_id   = g_src[NUM_SRC].win_id_l;
  assign win_prio = g_src[NUM_SRC].win_prio_l;
  assign rd_prio  = g_src[NUM_SRC].rd_prio_l;

  // Enable and threshold registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      enable_q    <= '0;
      threshold_q <= '0;
    end else if (wr_req) begin
      if (word == WORD_ENABLE) enable_q    <= reg_wdata[NUM_SRC:1];
      if (word == WORD_THRESH) threshold_q <= reg_wdata[PRIO_W-1:0];
    end
  end

  // Registered winner; a claim blanks it for one edge so the claimed ID
  // cannot be returned twice before its gateway leaves PENDING.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      best_id   <= '0;
      best_prio <= '0;
      ext_int   <= 1'b0;
    end else if (claim_go) begin
      best_id   <= '0;
      best_prio <= '0;
      ext_int   <= 1'b0;
    end else begin
      best_id   <= win_id;
      best_prio <= win_prio;
      ext_int   <= (win_id != '0);
    end
  end

  // Read data mux; unmapped words fall through as zero.
  always_comb begin
    rd_data               = '0;
    rd_data[PRIO_W-1:0]   = rd_prio;
    case (word)
      WORD_PENDING: rd_data[NUM_SRC:1]  = pending;
      WORD_ENABLE:  rd_data[NUM_SRC:1]  = enable_q;
      WORD_THRESH:  rd_data[PRIO_W-1:0] = threshold_q;
      WORD_CLAIM:   rd_data[4:0]        = best_id;
      default:      ;
    endcase
  end

  // Registered read response, one cycle after the accepted read.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      reg_rvalid <= 1'b0;
      reg_rdata  <= '0;
    end else begin
      reg_rvalid <= rd_req;
      if (rd_req) reg_rdata <= rd_data;
    end
  end

endmodule

// File: tb/tb_ext_irq_arbiter.sv
// Scoreboard bench for ext_irq_arbiter: a driver advances a behavioural model
// at every clock edge and queues expected read data; a monitor on the falling
// edge compares ext_int, reg_rvalid and popped read data.
module tb_ext_irq_arbiter;

  localparam int N  = 8;
  localparam int PW = 3;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] irq_src = '0;
  logic         reg_valid = 1'b0;
  logic         reg_write = 1'b0;
  logic [7:0]   reg_addr = '0;
  logic [31:0]  reg_wdata = '0;
  logic         reg_rvalid;
  logic [31:0]  reg_rdata;
  logic         ext_int;

  always #5 clock = ~clock;

  ext_irq_arbiter #(.NUM_SRC(N), .PRIO_W(PW)) dut (
    .clock      (clock),
    .reset      (reset),
    .irq_src    (irq_src),
    .reg_valid  (reg_valid),
    .reg_write  (reg_write),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_rvalid (reg_rvalid),
    .reg_rdata  (reg_rdata),
    .ext_int    (ext_int)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: sets of pending/claimed IDs plus programmed registers.
  logic [31:0] m_pend = '0;
  logic [31:0] m_clmd = '0;
  logic [31:0] m_en   = '0;
  int unsigned m_prio [32];
  int unsigned m_thr  = 0;
  int unsigned m_best = 0;
  logic        m_ext  = 1'b0;
  logic        m_rv   = 1'b0;
  logic [31:0] exp_q [$];
  logic [31:0] exp_d;

  localparam logic [31:0] EN_MASK = ((32'd1 << (N + 1)) - 32'd1) & ~32'd1;

  function automatic bit is_eligible(int unsigned i);
    return m_pend[i] && m_en[i] && (m_prio[i] > m_thr);
  endfunction

  // Highest priority among eligible sources, then the smallest ID holding it.
  function automatic int unsigned ref_winner();
    int unsigned top = 0;
    for (int unsigned i = 1; i <= N; i++)
      if (is_eligible(i) && m_prio[i] > top) top = m_prio[i];
    if (top == 0) return 0;
    for (int unsigned i = 1; i <= N; i++)
      if (is_eligible(i) && m_prio[i] == top) return i;
    return 0;
  endfunction

  // Apply one clock edge to the model using the inputs currently driven.
  task automatic model_edge();
    int unsigned w   = int'(reg_addr[7:2]);
    int unsigned win = ref_winner();
    logic [31:0] rd  = '0;
    logic [31:0] np  = m_pend;
    logic [31:0] nc  = m_clmd;
    bit claim, comp;
    m_rv = reg_valid && !reg_write;
    if (m_rv) begin
      if (w >= 1 && w <= N) rd = m_prio[w];
      else if (w == 32) rd = m_pend;
      else if (w == 33) rd = m_en;
      else if (w == 34) rd = m_thr;
      else if (w == 35) rd = m_best;
      exp_q.push_back(rd);
    end
    claim = m_rv && (w == 35) && (m_best != 0);
    comp  = reg_valid && reg_write && (w == 35);
    for (int unsigned i = 1; i <= N; i++) begin
      if (m_pend[i]) begin
        if (claim && m_best == i) begin np[i] = 1'b0; nc[i] = 1'b1; end
      end else if (m_clmd[i]) begin
        if (comp && int'(reg_wdata[4:0]) == i) nc[i] = 1'b0;
      end else if (irq_src[i-1]) begin
        np[i] = 1'b1;
      end
    end
    m_pend = np;
    m_clmd = nc;
    if (reg_valid && reg_write) begin
      if (w >= 1 && w <= N) m_prio[w] = reg_wdata & ((32'd1 << PW) - 32'd1);
      else if (w == 33) m_en = reg_wdata & EN_MASK;
      else if (w == 34) m_thr = reg_wdata & ((32'd1 << PW) - 32'd1);
    end
    m_best = claim ? 0 : win;
    m_ext  = (m_best != 0);
  endtask

  task automatic cyc(input logic v, input logic w, input logic [7:0] a, input logic [31:0] d);
    reg_valid = v;
    reg_write = w;
    reg_addr  = a;
    reg_wdata = d;
    @(posedge clock);
    model_edge();
    #1;
    reg_valid = 1'b0;
    reg_write = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    cyc(1'b1, 1'b1, a, d);
  endtask

  task automatic rd(input logic [7:0] a);
    cyc(1'b1, 1'b0, a, 32'd0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 8'h00, 32'd0);
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    m_pend = '0;
    m_clmd = '0;
    m_en   = '0;
    m_thr  = 0;
    m_best = 0;
    m_ext  = 1'b0;
    m_rv   = 1'b0;
    for (int i = 0; i < 32; i++) m_prio[i] = 0;
    exp_q.delete();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  // Monitor: compare outputs against the model on the falling edge.
  always @(negedge clock) begin
    checks++;
    if (ext_int !== m_ext) begin
      errors++;
      $display("FAIL ext_int @%0t: got %b, expected %b", $time, ext_int, m_ext);
    end
    checks++;
    if (reg_rvalid !== m_rv) begin
      errors++;
      $display("FAIL reg_rvalid @%0t: got %b, expected %b", $time, reg_rvalid, m_rv);
    end
    if (m_rv && exp_q.size() > 0) begin
      exp_d = exp_q.pop_front();
      checks++;
      if (reg_rdata !== exp_d) begin
        errors++;
        $display("FAIL reg_rdata @%0t: got 0x%08h, expected 0x%08h", $time, reg_rdata, exp_d);
      end
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) m_prio[i] = 0;

    // Reset values, then all lines high with nothing enabled.
    do_reset();
    rd(8'h04); rd(8'h80); rd(8'h84); rd(8'h88); rd(8'h8C);
    irq_src = '1;
    idle(2);
    rd(8'h80);
    idle(2);

    // Basic flow on source 3.
    irq_src = '0;
    do_reset();
    wr(8'h0C, 32'd2); wr(8'h84, 32'h08); wr(8'h88, 32'd0);
    irq_src = 8'h04; idle(1);
    irq_src = 8'h00; idle(2);
    rd(8'h8C); rd(8'h80);
    irq_src = 8'h04; idle(1);
    irq_src = 8'h00; idle(2);
    wr(8'h8C, 32'd3);
    irq_src = 8'h04; idle(1);
    irq_src = 8'h00; idle(3);
    rd(8'h8C); wr(8'h8C, 32'd3); idle(1);

    // Priority and tie-break.
    do_reset();
    wr(8'h08, 32'd5); wr(8'h14, 32'd5); wr(8'h1C, 32'd6); wr(8'h84, 32'hA4);
    irq_src = 8'h52; idle(1);
    irq_src = 8'h00; idle(2);
    for (int k = 0; k < 4; k++) begin rd(8'h8C); idle(1); end

    // Threshold.
    do_reset();
    wr(8'h04, 32'd3); wr(8'h84, 32'h02); wr(8'h88, 32'd3);
    irq_src = 8'h01; idle(3);
    wr(8'h88, 32'd2); idle(3);
    irq_src = 8'h00;

    // Claim racing a new pending source; complete of a pending ID.
    do_reset();
    wr(8'h18, 32'd4); wr(8'h10, 32'd2); wr(8'h84, 32'h50);
    irq_src = 8'h20; idle(1);
    irq_src = 8'h00; idle(2);
    irq_src = 8'h08; rd(8'h8C);
    irq_src = 8'h00; idle(1);
    wr(8'h8C, 32'd4); rd(8'h80); rd(8'h8C); rd(8'h80);
    wr(8'h8C, 32'd6); wr(8'h8C, 32'd4); idle(2);

    // Reset with a claimed and a pending source, levels held high.
    do_reset();
    wr(8'h08, 32'd3); wr(8'h0C, 32'd2); wr(8'h84, 32'h0C);
    irq_src = 8'h06; idle(2);
    rd(8'h8C); idle(1);
    do_reset();
    idle(3);
    rd(8'h80); rd(8'h8C); idle(1);
    irq_src = 8'h00;

    // Randomized traffic.
    for (int k = 0; k < 2000; k++) begin
      int unsigned op = $urandom_range(0, 9);
      logic [31:0] d = $urandom;
      if ($urandom_range(0, 3) == 0) irq_src = N'($urandom);
      case (op)
        1: wr(8'($urandom_range(1, N) * 4), d);
        2: wr(8'h84, d);
        3: wr(8'h88, (d & ~32'h7) | 32'($urandom_range(0, 4)));
        4, 5: rd(8'h8C);
        6: wr(8'h8C, (d & ~32'h1F) | 32'($urandom_range(0, 9)));
        7: rd(8'($urandom_range(0, 63) * 4));
        8: wr(8'($urandom_range(0, 63) * 4), d);
        default: idle(1);
      endcase
      if (k % 700 == 699) do_reset();
    end
    idle(2);
    #6;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL read_queue: %0d responses outstanding, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
